// File: rtl/rl_pkg.sv
// Shared constants and types for the rate limiter / PWM driver chain.
package rl_pkg;
  localparam int DATA_W     = 6;
  localparam int PRESCALE_W = 4;
  localparam int PWM_MAX    = (1 << DATA_W) - 1;

  typedef logic [DATA_W-1:0]     level_t;
  typedef logic [PRESCALE_W-1:0] ps_t;
endpackage

// File: rtl/rl_prescaler.sv
// Clock prescaler: one tick every (ps_shadow+1) clocks; the divide value is
// double-buffered and reloads on load (period boundary) or while disabled.
module rl_prescaler
  import rl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  ps_t  prescale,
  output logic tick
);
  ps_t ps_shadow;
  ps_t pcnt;

  assign tick = en && (pcnt == ps_shadow);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt      <= '0;
      ps_shadow <= '0;
    end else if (!en) begin
      pcnt      <= '0;
      ps_shadow <= prescale;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (load) ps_shadow <= prescale;
    end
  end
endmodule

// File: rtl/rl_pwm_driver.sv
// PWM driver for the 6-bit rate limiter output. Duty/prescale are shadowed and
// swap only at period boundaries. Define RL_PWM_CENTER_ALIGN_EN for a
// centre-aligned (up/down, 126-tick) period instead of the 63-tick sawtooth.
module rl_pwm_driver
  import rl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  level_t duty_in,
  input  ps_t    prescale,
  output logic   pwm_out,
  output logic   period_start,
  output level_t duty_active
);
  localparam level_t CNT_TOP = level_t'(PWM_MAX - 1);

  logic   tick;
  logic   boundary;
  level_t cnt;

  rl_prescaler u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (boundary),
    .prescale (prescale),
    .tick     (tick)
  );

`ifdef RL_PWM_CENTER_ALIGN_EN
  logic dir_down;

  // Both end values are held for one extra tick while the direction flips.
  assign boundary = tick && dir_down && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (tick) begin
      if (!dir_down) begin
        if (cnt == CNT_TOP) dir_down <= 1'b1;
        else                cnt      <= cnt + 1'b1;
      end else begin
        if (cnt == '0) dir_down <= 1'b0;
        else           cnt      <= cnt - 1'b1;
      end
    end
  end
`else
  assign boundary = tick && (cnt == CNT_TOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (!en)      cnt <= '0;
    else if (boundary) cnt <= '0;
    else if (tick)     cnt <= cnt + 1'b1;
  end
`endif

  // tick is gated by en, so a boundary coinciding with en=0 never fires here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      duty_active  <= '0;
    end else if (!en) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      duty_active  <= duty_in;
    end else begin
      pwm_out      <= (cnt < duty_active);
      period_start <= boundary;
      if (boundary) duty_active <= duty_in;
    end
  end
endmodule

// File: tb/tb_rl_pwm_driver.sv
// Self-checking bench for rl_pwm_driver: phase-based reference model compared
// every cycle, plus directed windows with hand-computed pulse counts.
module tb_rl_pwm_driver;
`ifdef RL_PWM_CENTER_ALIGN_EN
  localparam int MULT = 2;
`else
  localparam int MULT = 1;
`endif
  localparam int NT = 63 * MULT;   // ticks per period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [5:0] duty_in = '0;
  logic [3:0] prescale = '0;
  logic       pwm_out;
  logic       period_start;
  logic [5:0] duty_active;

  int checks = 0;
  int errors = 0;

  rl_pwm_driver dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .prescale     (prescale),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: position in the period as a plain clock count; the tick
  // index is clk/(ps+1) and the level is that index (folded for centre mode).
  initial begin
    int m_clk, m_duty, m_ps, e_pwm, e_st, e_da, l, p, t, lvl;
    m_clk = 0; m_duty = 0; m_ps = 0; e_pwm = 0; e_st = 0; e_da = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_clk = 0; m_duty = 0; m_ps = 0; e_pwm = 0; e_st = 0; e_da = 0;
      end
      chk("pwm_out", pwm_out, e_pwm);
      chk("period_start", period_start, e_st);
      chk("duty_active", duty_active, e_da);
      if (rst) begin
        if (!en) begin
          m_clk = 0; m_duty = duty_in; m_ps = prescale; e_pwm = 0; e_st = 0;
        end else begin
          l = m_ps + 1;
          p = NT * l;
          t = m_clk / l;
          lvl = (t < 63) ? t : 125 - t;
          e_pwm = (lvl < m_duty) ? 1 : 0;
          if (m_clk == p - 1) begin
            m_clk = 0; m_duty = duty_in; m_ps = prescale; e_st = 1;
          end else begin
            m_clk++; e_st = 0;
          end
        end
        e_da = m_duty;
      end
    end
  end

  task automatic step_in();
    @(posedge clk);
    #2;
  endtask

  task automatic window(input int n, output int hi, output int st);
    hi = 0; st = 0;
    repeat (n) begin
      @(negedge clk);
      hi += pwm_out;
      st += period_start;
    end
  endtask

  task automatic wait_start(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_start) break;
    end
    chk("wait_start_timeout", (i < budget) ? 1 : 0, 1);
  endtask

  initial begin
    int hi, st, h2, s2, p;
    p = NT;

    // Reset held with live inputs
    rst = 1'b0; en = 1'b1; duty_in = 6'd40; prescale = 4'd0;
    repeat (5) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_duty_active", duty_active, 0);
    chk("rst_period_start", period_start, 0);
    step_in(); rst = 1'b1;
    wait_start(p + 10);
    chk("first_load", duty_active, 40);
    window(p, hi, st);
    chk("duty40_high", hi, 40 * MULT);
    chk("duty40_starts", st, 1);

    // Basic duty
    step_in(); duty_in = 6'd20;
    wait_start(p + 5);
    window(p, hi, st);
    chk("duty20_high", hi, 20 * MULT);
    chk("duty20_starts", st, 1);

    // Double buffering: change mid-period
    window(11, hi, st);
    step_in(); duty_in = 6'd50;
    window(p - 11, h2, s2);
    chk("dbuf_keep_high", hi + h2, 20 * MULT);
    chk("dbuf_keep_starts", st + s2, 1);
    window(p, hi, st);
    chk("dbuf_new_high", hi, 50 * MULT);

    // Extremes
    step_in(); duty_in = 6'd0;
    wait_start(p + 5);
    window(p, hi, st);
    chk("duty0_high", hi, 0);
    step_in(); duty_in = 6'd63;
    wait_start(p + 5);
    window(3 * p, hi, st);
    chk("duty63_high", hi, 3 * p);
    chk("duty63_starts", st, 3);

    // Prescale 3, then a mid-period prescale change
    step_in(); duty_in = 6'd10; prescale = 4'd3;
    wait_start(p + 5);
    window(4 * p, hi, st);
    chk("ps3_high", hi, 40 * MULT);
    chk("ps3_starts", st, 1);
    window(100, hi, st);
    step_in(); prescale = 4'd0;
    window(4 * p - 100, h2, s2);
    chk("ps_hold_high", hi + h2, 40 * MULT);
    chk("ps_hold_starts", st + s2, 1);
    window(p, hi, st);
    chk("ps0_high", hi, 10 * MULT);

    // Enable dropped mid-period
    step_in(); duty_in = 6'd40;
    wait_start(p + 5);
    window(30, hi, st);
    chk("pre_en_off_pwm", pwm_out, 1);
    step_in(); en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("en_off_pwm", pwm_out, 0);
    repeat (3) @(negedge clk);
    step_in(); duty_in = 6'd25; prescale = 4'd1;
    step_in(); en = 1'b1;
    window(2 * p + 1, hi, st);
    chk("en_on_high", hi, 50 * MULT);
    chk("en_on_starts", st, 1);

    // en falling on the exact boundary edge: en wins, shadows still load
    window(2 * p - 2, hi, st);
    step_in(); en = 1'b0; duty_in = 6'd33;
    @(negedge clk);
    @(negedge clk);
    chk("bnd_en_off_start", period_start, 0);
    chk("bnd_en_off_duty", duty_active, 33);

    // Async reset mid-period
    step_in(); en = 1'b1;
    window(91, hi, st);
    step_in(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_duty_active", duty_active, 0);
    chk("mid_rst_pwm", pwm_out, 0);
    repeat (2) @(negedge clk);
    step_in(); rst = 1'b1;
    wait_start(p + 10);
    chk("post_rst_load", duty_active, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rl_pwm_driver.md
Name: rl_pwm_driver

Overview:
- Downstream stage of the 6-bit rate limiter: consumes its 6-bit output level and turns it into a single-bit PWM drive signal.
- Duty and prescale are double-buffered and update only at period boundaries, so the limiter's per-clock steps never produce glitched pulses.
- Output `period_start` is a per-period strobe for monitors and for pacing the limiter.

Parameters:
- DATA_W, 6, width of the duty input; the PWM period is (2^DATA_W - 1) ticks.
- PRESCALE_W, 4, width of the clock prescaler divide field.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset); deassertion is synchronous to clk at system level.
- en  input  1  run enable; 0 holds the counters idle.
- duty_in  input  DATA_W  requested level, driven by the rate limiter output.
- prescale  input  PRESCALE_W  tick divider; one tick every (prescale+1) clocks.
- pwm_out  output  1  registered PWM drive.
- period_start  output  1  one-clock pulse on each period boundary.
- duty_active  output  DATA_W  shadow duty currently in use.

Behaviour:
- Reset (rst=0, async): pwm_out=0, period_start=0, duty_active=0, prescale shadow=0, tick counter=0, period counter cnt=0.
- Prescaler:
  - Counter runs 0..ps_shadow and issues `tick` when it equals ps_shadow, then wraps to 0.
  - ps_shadow=0 gives a tick every clock.
- Period counter cnt (DATA_W bits):
  - Advances only on tick, counting 0..62 (DATA_W=6), then wraps to 0.
  - Period = 63 ticks.
- Boundary event: tick && cnt==62.
  - Same edge: cnt<=0, duty_active<=duty_in, ps_shadow<=prescale, period_start<=1.
  - period_start is 0 on all other cycles.
- Compare: pwm_out <= en && (cnt < duty_active), registered, so pwm_out lags cnt by one clock.
  - duty 0: output always low.
  - duty 63: output always high (cnt never reaches 63).
  - duty k: k high ticks per 63-tick period, left-aligned.
- en=0:
  - Prescaler and cnt are held at 0; pwm_out<=0; period_start=0.
  - duty_active<=duty_in and ps_shadow<=prescale every clock.
- en 0->1: the first period starts at cnt=0 using the duty and prescale values latched on the last en=0 cycle. No period_start pulse for this first period.
- Changes to duty_in or prescale mid-period: ignored until the next boundary.
- Reset mid-period: immediate async clear; after release the block resumes from cnt=0.
- Simultaneous boundary event and en falling: en=0 wins. Counters clear, and the shadows still load duty_in/prescale.

Optional Feature:
- Macro RL_PWM_CENTER_ALIGN_EN.
- Defined: cnt is an up/down triangle.
  - Sequence: up 0..62, then down 62..0 (both end values repeat once), giving a 126-tick period.
  - Direction flag resets to up.
  - pwm_out high while cnt < duty_active, giving 2*duty high ticks centred on cnt=0.
  - Boundary event = tick && dir==down && cnt==0; shadow loads and period_start occur there.
  - en=0 also forces dir=up.
- Undefined: edge-aligned 63-tick sawtooth exactly as above. The direction flag is not present.

Decomposition:
- Package rl_pkg:
  - DATA_W=6 and PRESCALE_W=4 constants shared with rate_limiter.
  - PWM_MAX = 2^DATA_W - 1.
  - Typedef level_t = logic [DATA_W-1:0].
- One sub-module, rl_prescaler: prescale counter plus tick output, with en and load inputs.
- Period counter, shadows and compare stay in rl_pwm_driver.

Test Plan:
- Reset: hold rst=0 with duty_in=40, en=1 -> pwm_out=0, duty_active=0, period_start=0. Release -> duty_active=40 after the first boundary.
- Basic duty: prescale=0, duty_in=20, en=1 -> per 63-clock period, pwm_out high exactly 20 clocks; period_start pulses every 63 clocks.
- Extremes: duty 0 -> pwm_out never high. Duty 63 -> pwm_out constantly 1 across 3 periods.
- Double buffering: change duty_in 20->50 at cnt=10 -> current period keeps 20 high ticks, next period has 50.
- Prescale: prescale=3, duty_in=10 -> period = 252 clocks, high = 40 clocks. A prescale change mid-period takes effect only after the boundary.
- Enable/reset mid-period: en 1->0 at cnt=30 -> pwm_out=0 next clock and cnt=0. rst pulse at cnt=45 -> async clear. With RL_PWM_CENTER_ALIGN_EN, duty_in=10 -> 20 high ticks per 126-tick period, centred on the boundary.
